// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: RUN / MEMWAIT / ERROR FSM driving latch enables and flushes.
// Optional stall cycle counter enabled by defining PIPELINE_CTRL_STALL_COUNT_EN.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] ex_rt,
    input  logic       ex_memread,
    input  logic       exmem_branch,
    input  logic       exmem_jump,
    input  logic       exmem_zero,
    input  logic       exmem_memread,
    input  logic       exmem_memwrite,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_write,
    output logic       exmem_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       pc_src,
    output logic       mem_req,
    output logic       mem_error,
    output logic       busy
`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       mem_error_q, mem_error_next;
    logic       access, taken, load_use, resolve;

    assign access   = exmem_memread | exmem_memwrite;
    assign taken    = (exmem_branch & exmem_zero) | exmem_jump;
    assign load_use = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    // Cycles in which the pipeline advances: RUN without a new stall, or the MEMWAIT completion cycle.
    assign resolve  = ((state == RUN) & ~(access & ~mem_ready)) | ((state == MEMWAIT) & mem_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            mem_error_q <= mem_error_next;
        end
    end

    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        mem_error_next = mem_error_q;
        case (state)
            RUN: begin
                wait_cnt_next = '0;
                if (access && !mem_ready) begin
                    state_next    = MEMWAIT;
                    wait_cnt_next = 8'd1;
                end
            end
            MEMWAIT: begin
                if (mem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
                    state_next     = ERROR;
                    mem_error_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_next = ERROR;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_src      = 1'b0;
        mem_req     = access & (state != ERROR);
        mem_error   = mem_error_q;
        busy        = (state != RUN);
        if (resolve) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            if (taken) begin
                pc_src      = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_write && stall_count != '1) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a cycle model pushes expected outputs, tests pop and compare.
module tb_pipeline_ctrl;

    localparam int unsigned TO = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       emr;
        logic       br;
        logic       jmp;
        logic       zero;
        logic       rd;
        logic       wr;
        logic       rdy;
    } stim_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic ex_memread = 1'b0, exmem_branch = 1'b0, exmem_jump = 1'b0, exmem_zero = 1'b0;
    logic exmem_memread = 1'b0, exmem_memwrite = 1'b0, mem_ready = 1'b0;
    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, exmem_flush, pc_src, mem_req, mem_error, busy;
`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;

    logic [10:0] sb[$];
    stim_t       cur;
    int          m_state;
    int          m_cnt;
    int          m_sc;

    always #5 clock = ~clock;

    pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .ex_memread(ex_memread),
        .exmem_branch(exmem_branch), .exmem_jump(exmem_jump), .exmem_zero(exmem_zero),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .pc_src(pc_src), .mem_req(mem_req),
        .mem_error(mem_error), .busy(busy)
`ifdef PIPELINE_CTRL_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    assign outs = {pc_write, ifid_write, idex_write, exmem_write,
                   ifid_flush, idex_flush, exmem_flush, pc_src, mem_req, mem_error, busy};

    function automatic stim_t s(logic rst, logic [4:0] ert, logic [4:0] rs, logic [4:0] rt,
                                logic emr, logic br, logic jmp, logic zero,
                                logic rd, logic wr, logic rdy);
        stim_t t;
        t = '{rst:rst, ert:ert, rs:rs, rt:rt, emr:emr, br:br, jmp:jmp, zero:zero,
              rd:rd, wr:wr, rdy:rdy};
        return t;
    endfunction

    // Expected outputs for the current model state (0 RUN, 1 MEMWAIT, 2 ERROR).
    function automatic logic [10:0] model_out(stim_t t);
        logic taken, haz, req;
        logic [3:0] we;
        logic [2:0] fl;
        logic ps;
        taken = (t.br & t.zero) | t.jmp;
        haz   = t.emr && (t.ert != 5'd0) && ((t.ert == t.rs) || (t.ert == t.rt));
        req   = t.rd | t.wr;
        we = '0; fl = '0; ps = 1'b0;
        if ((m_state == 0 && !(req && !t.rdy)) || (m_state == 1 && t.rdy)) begin
            we = '1;
            if (taken) begin
                fl = '1;
                ps = 1'b1;
            end else if (haz) begin
                we = 4'b0011;
                fl = 3'b010;
            end
        end
        return {we, fl, ps, req && (m_state != 2), m_state == 2, m_state != 0};
    endfunction

    always @(posedge clock or posedge reset) begin
        logic [10:0] o;
        if (reset) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_sc    <= 0;
        end else begin
            o = model_out(cur);
            if (!o[10] && m_sc < 16'hFFFF) m_sc <= m_sc + 1;
            case (m_state)
                0: if ((cur.rd | cur.wr) && !cur.rdy) begin m_state <= 1; m_cnt <= 1; end
                1: begin
                    if (cur.rdy) begin m_state <= 0; m_cnt <= 0; end
                    else if (m_cnt == int'(TO)) m_state <= 2;
                    else m_cnt <= m_cnt + 1;
                end
                default: m_state <= 2;
            endcase
        end
    end

    task automatic drive(input stim_t t);
        @(posedge clock);
        #1;
        cur            = t;
        reset          = t.rst;
        ex_rt          = t.ert;
        id_rs          = t.rs;
        id_rt          = t.rt;
        ex_memread     = t.emr;
        exmem_branch   = t.br;
        exmem_jump     = t.jmp;
        exmem_zero     = t.zero;
        exmem_memread  = t.rd;
        exmem_memwrite = t.wr;
        mem_ready      = t.rdy;
        #1;
        sb.push_back(model_out(t));
        @(negedge clock);
    endtask

    task automatic test_reset();
        stim_t rows[$];
        logic [10:0] exp;
        rows = '{s(1,0,0,0,0,0,0,0,0,0,0), s(1,5,5,0,1,0,0,0,0,0,0),
                 s(1,0,0,0,0,1,0,1,0,0,0), s(0,0,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL reset row %0d got %b want %b", i, outs, exp);
            end
        end
        checks++;
        if (outs !== 11'b1111_000_0_0_0_0) begin
            errors++;
            $display("FAIL reset_defaults got %b want %b", outs, 11'b1111_000_0_0_0_0);
        end
    endtask

    task automatic test_load_use();
        stim_t rows[$];
        logic [10:0] exp;
        rows = '{s(0,5,5,0,1,0,0,0,0,0,0), s(0,0,0,0,0,0,0,0,0,0,0),
                 s(0,0,0,0,1,0,0,0,0,0,0), s(0,9,3,9,1,0,0,0,0,0,0),
                 s(0,9,3,9,0,0,0,0,0,0,0), s(0,7,3,4,1,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL load_use row %0d got %b want %b", i, outs, exp);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t rows[$];
        logic [10:0] exp;
        rows = '{s(0,0,0,0,0,0,0,0,1,0,1), s(0,0,0,0,0,0,0,0,1,0,0),
                 s(0,0,0,0,0,0,0,0,1,0,0), s(0,0,0,0,0,0,0,0,1,0,0),
                 s(0,0,0,0,0,0,0,0,1,0,1), s(0,0,0,0,0,0,0,0,0,0,0),
                 s(0,0,0,0,0,0,0,0,0,1,0), s(0,0,0,0,0,0,0,0,0,1,1),
                 s(0,0,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL mem_wait row %0d got %b want %b", i, outs, exp);
            end
        end
    endtask

    task automatic test_branch();
        stim_t rows[$];
        logic [10:0] exp;
        rows = '{s(0,0,0,0,0,1,0,1,0,0,0), s(0,0,0,0,0,0,0,0,0,0,0),
                 s(0,0,0,0,0,1,0,0,0,0,0), s(0,0,0,0,0,0,1,0,0,0,0),
                 s(0,0,0,0,0,0,0,1,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL branch row %0d got %b want %b", i, outs, exp);
            end
        end
    endtask

    task automatic test_priority();
        stim_t rows[$];
        logic [10:0] exp;
        rows = '{s(0,5,5,0,1,1,0,1,0,0,0), s(0,0,0,0,0,0,0,0,1,0,0),
                 s(0,0,0,0,0,1,0,1,1,0,0), s(0,0,0,0,0,0,1,0,1,0,0),
                 s(0,0,0,0,0,1,0,1,1,0,1), s(0,0,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL priority row %0d got %b want %b", i, outs, exp);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t rows[$];
        logic [10:0] exp;
        rows = '{s(0,0,0,0,0,0,0,0,1,0,0), s(0,0,0,0,0,0,0,0,1,0,0),
                 s(0,0,0,0,0,0,0,0,1,0,0), s(0,0,0,0,0,0,0,0,1,0,0),
                 s(0,0,0,0,0,0,0,0,1,0,0), s(0,0,0,0,0,1,0,1,1,0,0),
                 s(0,0,0,0,0,0,0,0,1,0,1), s(1,0,0,0,0,0,0,0,0,0,0),
                 s(0,0,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp = sb.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL timeout row %0d got %b want %b", i, outs, exp);
            end
            if (i == 6) begin
                checks++;
                if (mem_error !== 1'b1 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_error got err=%b req=%b want err=1 req=0",
                             mem_error, mem_req);
                end
            end
        end
    endtask

`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    task automatic test_stall_count();
        stim_t rows[$];
        logic [10:0] exp;
        rows = '{s(1,0,0,0,0,0,0,0,0,0,0), s(0,0,0,0,0,0,0,0,0,0,0),
                 s(0,0,0,0,0,0,0,0,1,0,0), s(0,0,0,0,0,0,0,0,1,0,0),
                 s(0,0,0,0,0,0,0,0,1,0,0), s(0,0,0,0,0,0,0,0,1,0,1),
                 s(0,5,5,0,1,0,0,0,0,0,0), s(0,0,0,0,0,0,0,0,0,0,0)};
        foreach (rows[i]) begin
            drive(rows[i]);
            exp = sb.pop_front();
            checks++;
            if (outs !== exp || stall_count !== 16'(m_sc)) begin
                errors++;
                $display("FAIL stall_count row %0d got %b/%0d want %b/%0d",
                         i, outs, stall_count, exp, m_sc);
            end
        end
        checks++;
        if (stall_count !== 16'd4) begin
            errors++;
            $display("FAIL stall_count_total got %0d want 4", stall_count);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = s(1,0,0,0,0,0,0,0,0,0,0);
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_priority();
        test_timeout();
`ifdef PIPELINE_CTRL_STALL_COUNT_EN
        test_stall_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
